// File: rtl/team_06_pkg.sv
// Shared types and constants for the SRAM audio word packer.
package team_06_pkg;

  // Default byte address of the circular audio recording region.
  localparam logic [31:0] SRAM_AUDIO_BASE = 32'h3300_0000;

  // Bus-side write sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    WAIT = 2'd3
  } state_t;

  // Byte address of a word slot inside the region.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] word_index);
    return base + (word_index << 2);
  endfunction

endpackage

// File: rtl/team_06_word_fifo.sv
// Two-entry, 32-bit word FIFO. Push and pop may coincide, including when full.
module team_06_word_fifo
  import team_06_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        clear,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);

  logic [31:0] mem_reg [2];
  logic        wr_idx_reg;
  logic        rd_idx_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        do_push;
  logic        do_pop;
  logic [1:0]  entry_we;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign head    = mem_reg[rd_idx_reg];
  // A pop frees the head slot in the same edge, so a full FIFO may still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry_we
      assign entry_we[gi] = do_push && (wr_idx_reg == 1'(gi));
    end
  endgenerate

  // Occupancy bookkeeping for simultaneous push/pop.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Storage: only the slot addressed by the write index is loaded.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (entry_we[i]) mem_reg[i] <= push_data;
      end
    end
  end

  // Pointers and count; clear discards all contents.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_idx_reg <= 1'b0;
      rd_idx_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (clear) begin
      wr_idx_reg <= 1'b0;
      rd_idx_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_idx_reg <= ~wr_idx_reg;
      if (do_pop)  rd_idx_reg <= ~rd_idx_reg;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/team_06_sram_word_packer.sv
// Packs 8-bit recorded samples into little-endian 32-bit words and writes
// them into a circular SRAM region through the wishbone manager user port.
module team_06_sram_word_packer
  import team_06_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_AUDIO_BASE,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  input  logic          enable,
  input  logic          clear,
  output logic [31:0]   busAudioWrite,
  output logic [31:0]   addressOut,
  output logic [3:0]    select,
  output logic          write,
  input  logic          busySRAM,
  output logic [AW-1:0] wr_ptr,
  output logic          overflow
);

  state_t        state_reg;
  state_t        state_next;
  logic [1:0]    lane_reg;
  logic [23:0]   pack_reg;
  logic [23:0]   pack_next;
  logic [AW-1:0] wr_ptr_reg;
  logic          overflow_reg;
  logic          abort_reg;
  logic          abort_next;
  logic          write_reg;
  logic [31:0]   data_reg;
  logic [31:0]   addr_reg;

  logic          accept;
  logic          push;
  logic [31:0]   push_word;
  logic          pop;
  logic          load_req;
  logic          wait_done;
  logic [31:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  assign select        = 4'hF;
  assign write         = write_reg;
  assign busAudioWrite = data_reg;
  assign addressOut    = addr_reg;
  assign wr_ptr        = wr_ptr_reg;
  assign overflow      = overflow_reg;

  // A strobe coinciding with clear is dropped so the rewind starts from a clean lane 0.
  assign accept    = sample_valid && enable && !clear;
  assign push      = accept && (lane_reg == 2'd3);
  assign push_word = {sample_in, pack_reg};
  assign wait_done = (state_reg == WAIT) && !busySRAM;
  // A transaction interrupted by clear still finishes on the bus but must not
  // consume a word or advance the pointer.
  assign pop       = wait_done && !abort_reg && !clear;

  // Lanes 0..2 are staged; lane 3 goes straight into the FIFO with them.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign pack_next[gi*8 +: 8] = (lane_reg == 2'(gi)) ? sample_in : pack_reg[gi*8 +: 8];
    end
  endgenerate

  team_06_word_fifo u_fifo (
    .clk       (clk),
    .nRST      (nRST),
    .clear     (clear),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Lane counter and partial word; disabled strobes leave both untouched.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      lane_reg <= 2'd0;
      pack_reg <= '0;
    end else if (clear) begin
      lane_reg <= 2'd0;
      pack_reg <= '0;
    end else if (accept) begin
      lane_reg <= lane_reg + 2'd1;
      pack_reg <= pack_next;
    end
  end

  // Sticky overflow: a completed word found no room and nothing left this cycle.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      overflow_reg <= 1'b0;
    end else if (clear) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  // Word pointer into the circular region; wraps naturally at DEPTH_WORDS.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
    end else if (pop) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      abort_reg <= abort_next;
    end
  end

  // Next-state logic: IDLE -> REQ -> GAP -> WAIT (until not busy) -> IDLE.
  always_comb begin
    state_next = state_reg;
    load_req   = 1'b0;
    abort_next = abort_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !busySRAM && !clear) begin
          state_next = REQ;
          load_req   = 1'b1;
        end
      end
      REQ:  state_next = GAP;
      GAP:  state_next = WAIT;
      WAIT: begin
        if (!busySRAM) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (wait_done) begin
      abort_next = 1'b0;
    end else if (clear && (state_reg != IDLE)) begin
      abort_next = 1'b1;
    end
  end

  // Registered bus outputs; data and address hold until the next request is launched.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      write_reg <= 1'b0;
      data_reg  <= '0;
      addr_reg  <= BASE_ADDR;
    end else begin
      write_reg <= load_req;
      if (load_req) begin
        data_reg <= fifo_head;
        addr_reg <= word_addr(BASE_ADDR, 32'(wr_ptr_reg));
      end
    end
  end

endmodule

// File: tb/tb_team_06_sram_word_packer.sv
// Directed bench for the SRAM word packer, built with a 4-word region so wrap is reachable.
module tb_team_06_sram_word_packer;

  localparam logic [31:0] BASE = 32'h3300_0000;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          clk;
  logic          nRST;
  logic [7:0]    sample_in;
  logic          sample_valid;
  logic          enable;
  logic          clear;
  logic [31:0]   busAudioWrite;
  logic [31:0]   addressOut;
  logic [3:0]    select;
  logic          write;
  logic          busySRAM;
  logic [AW-1:0] wr_ptr;
  logic          overflow;

  int checks;
  int failures;

  logic [31:0] wq_data[$];
  logic [31:0] wq_addr[$];
  logic        prev_write;

  team_06_sram_word_packer #(
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk           (clk),
    .nRST          (nRST),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .enable        (enable),
    .clear         (clear),
    .busAudioWrite (busAudioWrite),
    .addressOut    (addressOut),
    .select        (select),
    .write         (write),
    .busySRAM      (busySRAM),
    .wr_ptr        (wr_ptr),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: logs every write and verifies write is never high two cycles running.
  initial prev_write = 1'b0;
  always @(negedge clk) begin
    if (write === 1'b1) begin
      checks++;
      if (prev_write === 1'b1) begin
        failures++;
        $display("FAIL write_spacing: write high on consecutive cycles at %0t, required single-cycle pulse", $time);
      end
      wq_data.push_back(busAudioWrite);
      wq_addr.push_back(addressOut);
      $display("WRITE data=%08h addr=%08h t=%0t", busAudioWrite, addressOut, $time);
    end
    prev_write = write;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_sample(w[i*8 +: 8]);
  endtask

  task automatic wait_writes(input int n, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wq_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (wq_data.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    tick();
    send_sample(8'hE1);
    sample_in    = 8'hE2;
    sample_valid = 1'b1;
    nRST         = 1'b0;
    tick();
    tick();
    sample_valid = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0 || busAudioWrite !== 32'h0 || addressOut !== BASE || select !== 4'hF) begin
      failures++;
      $display("FAIL reset_bus: write=%b data=%08h addr=%08h sel=%h, required 0/00000000/%08h/f",
               write, busAudioWrite, addressOut, select, BASE);
    end
    checks++;
    if (wr_ptr !== 2'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: wr_ptr=%0d overflow=%b, required 0/0", wr_ptr, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (write !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_write: write=%b in cycle %0d after reset, required 0", write, i);
      end
    end
    wq_data.delete();
    wq_addr.delete();
    $display("TEST reset done");
  endtask

  task automatic test_basic();
    send_sample(8'h11);
    send_sample(8'h22);
    send_sample(8'h33);
    sample_in    = 8'h44;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    checks++;
    if (write !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency_early: write=%b one cycle after 4th strobe, required 0", write);
    end
    tick();
    checks++;
    if (write !== 1'b1 || busAudioWrite !== 32'h4433_2211 || addressOut !== BASE) begin
      failures++;
      $display("FAIL basic_write: write=%b data=%08h addr=%08h, required 1/44332211/%08h",
               write, busAudioWrite, addressOut, BASE);
    end
    tick();
    tick();
    checks++;
    if (wr_ptr !== 2'd0 || busAudioWrite !== 32'h4433_2211) begin
      failures++;
      $display("FAIL basic_hold: wr_ptr=%0d data=%08h in WAIT, required 0/44332211", wr_ptr, busAudioWrite);
    end
    tick();
    checks++;
    if (wr_ptr !== 2'd1) begin
      failures++;
      $display("FAIL basic_ptr: wr_ptr=%0d after write, required 1", wr_ptr);
    end
    wq_data.delete();
    wq_addr.delete();
    $display("TEST basic done");
  endtask

  task automatic test_busy_stall();
    logic ok;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h0403_0201;
    exp_d[1] = 32'h0807_0605;
    exp_d[2] = 32'h0C0B_0A09;
    send_word(exp_d[0]);
    wait_writes(1, 20, ok);
    busySRAM = 1'b1;
    send_word(exp_d[1]);
    for (int i = 0; i < 88; i++) tick();
    checks++;
    if (wq_data.size() != 1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: writes=%0d overflow=%b during stall, required 1/0", wq_data.size(), overflow);
    end
    busySRAM = 1'b0;
    send_word(exp_d[2]);
    wait_writes(3, 60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout: writes=%0d, required 3", wq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq_data[i] !== exp_d[i] || wq_addr[i] !== BASE + 32'(4 * (i + 1))) begin
          failures++;
          $display("FAIL stall_write%0d: data=%08h addr=%08h, required %08h/%08h",
                   i, wq_data[i], wq_addr[i], exp_d[i], BASE + 32'(4 * (i + 1)));
        end
      end
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (wr_ptr !== 2'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL stall_end: wr_ptr=%0d overflow=%b, required 0/0", wr_ptr, overflow);
    end
    wq_data.delete();
    wq_addr.delete();
    $display("TEST busy_stall done");
  endtask

  task automatic test_wrap();
    logic ok;
    send_word(32'h5D5C_5B5A);
    wait_writes(1, 20, ok);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (!ok || wq_data[0] !== 32'h5D5C_5B5A || wq_addr[0] !== BASE || wr_ptr !== 2'd1) begin
      failures++;
      $display("FAIL wrap: ok=%b data=%08h addr=%08h wr_ptr=%0d, required 1/5d5c5b5a/%08h/1",
               ok, ok ? wq_data[0] : 32'h0, ok ? wq_addr[0] : 32'h0, wr_ptr, BASE);
    end
    wq_data.delete();
    wq_addr.delete();
    $display("TEST wrap done");
  endtask

  task automatic test_overflow();
    logic ok;
    busySRAM = 1'b1;
    send_word(32'h6463_6261);
    send_word(32'h7473_7271);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_early: overflow=%b with FIFO just full, required 0", overflow);
    end
    send_word(32'h8483_8281);
    checks++;
    if (overflow !== 1'b1 || wq_data.size() != 0) begin
      failures++;
      $display("FAIL ovf_set: overflow=%b writes=%0d, required 1/0", overflow, wq_data.size());
    end
    busySRAM = 1'b0;
    wait_writes(2, 40, ok);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (!ok || wq_data.size() != 2) begin
      failures++;
      $display("FAIL ovf_count: writes=%0d, required 2", wq_data.size());
    end else begin
      checks++;
      if (wq_data[0] !== 32'h6463_6261 || wq_addr[0] !== BASE + 32'd4 ||
          wq_data[1] !== 32'h7473_7271 || wq_addr[1] !== BASE + 32'd8) begin
        failures++;
        $display("FAIL ovf_data: %08h@%08h %08h@%08h, required 64636261@%08h 74737271@%08h",
                 wq_data[0], wq_addr[0], wq_data[1], wq_addr[1], BASE + 32'd4, BASE + 32'd8);
      end
    end
    checks++;
    if (wr_ptr !== 2'd3 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_end: wr_ptr=%0d overflow=%b, required 3/1", wr_ptr, overflow);
    end
    wq_data.delete();
    wq_addr.delete();
    $display("TEST overflow done");
  endtask

  task automatic test_clear();
    logic ok;
    send_word(32'h9493_9291);
    wait_writes(1, 20, ok);
    busySRAM = 1'b1;
    checks++;
    if (!ok || wq_data[0] !== 32'h9493_9291 || wq_addr[0] !== BASE + 32'd12) begin
      failures++;
      $display("FAIL clear_first: ok=%b data=%08h addr=%08h, required 1/94939291/%08h",
               ok, ok ? wq_data[0] : 32'h0, ok ? wq_addr[0] : 32'h0, BASE + 32'd12);
    end
    send_sample(8'hC1);
    send_sample(8'hC2);
    clear        = 1'b1;
    sample_in    = 8'hEE;
    sample_valid = 1'b1;
    tick();
    clear        = 1'b0;
    sample_valid = 1'b0;
    checks++;
    if (wr_ptr !== 2'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_state: wr_ptr=%0d overflow=%b, required 0/0", wr_ptr, overflow);
    end
    tick();
    tick();
    busySRAM = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (wr_ptr !== 2'd0 || wq_data.size() != 1) begin
      failures++;
      $display("FAIL clear_abort: wr_ptr=%0d writes=%0d after WAIT exit, required 0/1", wr_ptr, wq_data.size());
    end
    send_word(32'hA4A3_A2A1);
    wait_writes(2, 20, ok);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (!ok || wq_data[1] !== 32'hA4A3_A2A1 || wq_addr[1] !== BASE || wr_ptr !== 2'd1) begin
      failures++;
      $display("FAIL clear_repack: ok=%b data=%08h addr=%08h wr_ptr=%0d, required 1/a4a3a2a1/%08h/1",
               ok, ok ? wq_data[1] : 32'h0, ok ? wq_addr[1] : 32'h0, wr_ptr, BASE);
    end
    wq_data.delete();
    wq_addr.delete();
    $display("TEST clear done");
  endtask

  task automatic test_enable();
    logic ok;
    send_sample(8'hB1);
    send_sample(8'hB2);
    enable = 1'b0;
    send_sample(8'hDE);
    send_sample(8'hAD);
    enable = 1'b1;
    checks++;
    if (wq_data.size() != 0) begin
      failures++;
      $display("FAIL enable_ignored: writes=%0d while disabled, required 0", wq_data.size());
    end
    send_sample(8'hB3);
    send_sample(8'hB4);
    wait_writes(1, 20, ok);
    checks++;
    if (!ok || wq_data[0] !== 32'hB4B3_B2B1 || wq_addr[0] !== BASE + 32'd4) begin
      failures++;
      $display("FAIL enable_resume: ok=%b data=%08h addr=%08h, required 1/b4b3b2b1/%08h",
               ok, ok ? wq_data[0] : 32'h0, ok ? wq_addr[0] : 32'h0, BASE + 32'd4);
    end
    for (int i = 0; i < 6; i++) tick();
    wq_data.delete();
    wq_addr.delete();
    $display("TEST enable done");
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    nRST         = 1'b0;
    sample_in    = 8'h00;
    sample_valid = 1'b0;
    enable       = 1'b1;
    clear        = 1'b0;
    busySRAM     = 1'b0;
    tick();
    tick();
    test_reset();
    test_basic();
    test_busy_stall();
    test_wrap();
    test_overflow();
    test_clear();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
